bimodal_btb_pred: RTL and testbench

Parametrised bimodal direction predictor with a tagged, direct-mapped branch target buffer, for the fetch stage. Lookup is registered: a request is accepted on a valid/ready handshake, and the response appears the following cycle. Updates from the execute/commit stage train the saturating-counter table and allocate BTB entries. On reset, a hardware init sweep clears both tables before any lookup is accepted.

---
 rtl/bp_pkg.sv | 38 +++
 rtl/bp_btb.sv | 59 +++++
 rtl/bimodal_btb_pred.sv | 165 ++++++++++++++++
 tb/tb_bimodal_btb_pred.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the bimodal predictor slice.
// The BTB entry struct is sized from BP_PC_W / BP_BTB_IDX_W, so the top-level
// PC_W and BTB_IDX_W defaults are taken from here and must move together.
package bp_pkg;

    localparam int BP_PC_W      = 32;
    localparam int BP_BTB_IDX_W = 5;
    localparam int BP_TAG_W     = BP_PC_W - BP_BTB_IDX_W - 2;

    // Counter helpers operate on this container width; callers cast to CTR_W.
    localparam int CTR_W_MAX = 8;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_PC_W-1:0]  target;
    } btb_entry_t;

    // Weakly-not-taken value for a w-bit counter: MSB clear, all other bits set.
    function automatic logic [CTR_W_MAX-1:0] CTR_WEAK_NT(input int unsigned w);
        return (CTR_W_MAX'(1'b1) << (w - 1)) - 1'b1;
    endfunction

    function automatic logic [CTR_W_MAX-1:0] ctr_sat_inc(input logic [CTR_W_MAX-1:0] c,
                                                         input int unsigned w);
        logic [CTR_W_MAX-1:0] maxv;
        maxv = (CTR_W_MAX'(1'b1) << w) - 1'b1;
        return (c >= maxv) ? c : c + 1'b1;
    endfunction

    function automatic logic [CTR_W_MAX-1:0] ctr_sat_dec(input logic [CTR_W_MAX-1:0] c,
                                                         input int unsigned w);
        logic [CTR_W_MAX-1:0] unused_w;
        unused_w = CTR_W_MAX'(w);
        return (c == '0) ? c : c - 1'b1;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped, tagged branch target buffer: one registered read port with
// tag compare, one write port, and a valid-clear port driven by the init sweep.
module bp_btb
    import bp_pkg::*;
#(
    parameter int PC_W  = BP_PC_W,
    parameter int IDX_W = BP_BTB_IDX_W
) (
    input  logic             clk_i,
    input  logic             rd_en_i,
    input  logic [PC_W-1:0]  rd_pc_i,
    input  logic             clr_en_i,
    input  logic [IDX_W-1:0] clr_idx_i,
    input  logic             wr_en_i,
    input  logic [PC_W-1:0]  wr_pc_i,
    input  logic [PC_W-1:0]  wr_target_i,
    output logic             rd_hit_o,
    output logic [PC_W-1:0]  rd_target_o
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W - 2;

    btb_entry_t       mem_q [DEPTH];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;
    logic             rd_hit_q;
    logic [PC_W-1:0]  rd_target_q;
    logic             unused_pc_bits;

    assign rd_idx = rd_pc_i[IDX_W+1:2];
    assign wr_idx = wr_pc_i[IDX_W+1:2];
    assign rd_tag = rd_pc_i[PC_W-1:IDX_W+2];
    assign wr_tag = wr_pc_i[PC_W-1:IDX_W+2];
    assign unused_pc_bits = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

    // Table writes: the init clear only invalidates; a write allocates and overwrites any alias.
    always_ff @(posedge clk_i) begin
        if (clr_en_i) begin
            mem_q[clr_idx_i].valid <= 1'b0;
        end else if (wr_en_i) begin
            mem_q[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target_i};
        end
    end

    // Registered lookup: sees the table as it was before any same-edge write.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_hit_q    <= mem_q[rd_idx].valid && (mem_q[rd_idx].tag == rd_tag);
            rd_target_q <= mem_q[rd_idx].target;
        end
    end

    assign rd_hit_o    = rd_hit_q;
    assign rd_target_o = rd_target_q;

endmodule

// File: rtl/bimodal_btb_pred.sv
// Bimodal direction predictor (saturating-counter PHT) plus tagged BTB.
// Optional feature macro: BP_PERF_CNT_EN adds saturating 32-bit perf counters.
module bimodal_btb_pred
    import bp_pkg::*;
#(
    parameter int PC_W      = BP_PC_W,
    parameter int PHT_IDX_W = 8,
    parameter int CTR_W     = 2,
    parameter int BTB_IDX_W = BP_BTB_IDX_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lookup_valid,
    output logic            lookup_ready,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            resp_valid,
    output logic            resp_taken,
    output logic            resp_btb_hit,
    output logic [PC_W-1:0] resp_target,
    input  logic            update_valid,
    input  logic [PC_W-1:0] update_pc,
    input  logic            update_actual,
    input  logic [PC_W-1:0] update_target,
    input  logic            update_mispredict,
    output logic            init_busy
`ifdef BP_PERF_CNT_EN
   ,output logic [31:0]     perf_lookups,
    output logic [31:0]     perf_updates,
    output logic [31:0]     perf_mispredicts
`endif
);

    localparam int IDX_W     = (PHT_IDX_W > BTB_IDX_W) ? PHT_IDX_W : BTB_IDX_W;
    localparam int PHT_DEPTH = 1 << PHT_IDX_W;
    localparam int BTB_DEPTH = 1 << BTB_IDX_W;
    localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(CTR_WEAK_NT(CTR_W));

    typedef enum logic {INIT, RUN} state_e;

    state_e               state_q;
    logic [IDX_W-1:0]     init_idx_q;
    logic                 lookup_ready_q;
    logic                 init_busy_q;
    logic                 resp_valid_q;
    logic                 ctr_msb_q;
    logic [CTR_W-1:0]     pht_q [PHT_DEPTH];
    logic [CTR_W-1:0]     pht_cur;
    logic [CTR_W-1:0]     pht_d;
    logic [PHT_IDX_W-1:0] pht_lk_idx;
    logic [PHT_IDX_W-1:0] pht_upd_idx;
    logic                 lookup_fire;
    logic                 update_fire;
    logic                 btb_clr_en;
    logic                 btb_hit;
    logic [PC_W-1:0]      btb_target;

    // Lookups and updates only take effect once the sweep has finished.
    assign lookup_fire = lookup_valid & lookup_ready_q;
    assign update_fire = update_valid & lookup_ready_q;
    assign pht_lk_idx  = lookup_pc[PHT_IDX_W+1:2];
    assign pht_upd_idx = update_pc[PHT_IDX_W+1:2];
    assign pht_cur     = pht_q[pht_upd_idx];
    assign pht_d       = update_actual ? CTR_W'(ctr_sat_inc(CTR_W_MAX'(pht_cur), CTR_W))
                                       : CTR_W'(ctr_sat_dec(CTR_W_MAX'(pht_cur), CTR_W));
    assign btb_clr_en  = (state_q == INIT) && (32'(init_idx_q) < BTB_DEPTH);

    // Init sweep walks every index of the larger table once, then hands over to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= INIT;
            init_idx_q     <= '0;
            lookup_ready_q <= 1'b0;
            init_busy_q    <= 1'b1;
        end else if (state_q == INIT) begin
            init_idx_q <= init_idx_q + 1'b1;
            if (&init_idx_q) begin
                state_q        <= RUN;
                lookup_ready_q <= 1'b1;
                init_busy_q    <= 1'b0;
            end
        end
    end

    // PHT writes: sweep to weakly-not-taken, then train with saturating counters.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            pht_q[init_idx_q[PHT_IDX_W-1:0]] <= WEAK_NT;
        end else if (update_fire) begin
            pht_q[pht_upd_idx] <= pht_d;
        end
    end

    // Response valid is a one-cycle pulse and is killed immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
        end else begin
            resp_valid_q <= lookup_fire;
        end
    end

    // Only the direction bit of the counter is needed for the prediction.
    always_ff @(posedge clk) begin
        if (lookup_fire) begin
            ctr_msb_q <= pht_q[pht_lk_idx][CTR_W-1];
        end
    end

    bp_btb #(
        .PC_W  (PC_W),
        .IDX_W (BTB_IDX_W)
    ) u_btb (
        .clk_i       (clk),
        .rd_en_i     (lookup_fire),
        .rd_pc_i     (lookup_pc),
        .clr_en_i    (btb_clr_en),
        .clr_idx_i   (init_idx_q[BTB_IDX_W-1:0]),
        .wr_en_i     (update_fire & update_actual),
        .wr_pc_i     (update_pc),
        .wr_target_i (update_target),
        .rd_hit_o    (btb_hit),
        .rd_target_o (btb_target)
    );

    // A taken counter without a BTB hit has nowhere to go, so it predicts not-taken.
    assign lookup_ready = lookup_ready_q;
    assign init_busy    = init_busy_q;
    assign resp_valid   = resp_valid_q;
    assign resp_btb_hit = resp_valid_q & btb_hit;
    assign resp_taken   = resp_btb_hit & ctr_msb_q;
    assign resp_target  = resp_taken ? btb_target : '0;

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_lookups_q;
    logic [31:0] perf_updates_q;
    logic [31:0] perf_mispredicts_q;

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lookups_q     <= '0;
            perf_updates_q     <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            if (lookup_fire && !(&perf_lookups_q)) begin
                perf_lookups_q <= perf_lookups_q + 1'b1;
            end
            if (update_fire && !(&perf_updates_q)) begin
                perf_updates_q <= perf_updates_q + 1'b1;
            end
            if (update_fire && update_mispredict && !(&perf_mispredicts_q)) begin
                perf_mispredicts_q <= perf_mispredicts_q + 1'b1;
            end
        end
    end

    assign perf_lookups     = perf_lookups_q;
    assign perf_updates     = perf_updates_q;
    assign perf_mispredicts = perf_mispredicts_q;
`else
    logic unused_mispredict;
    assign unused_mispredict = update_mispredict;
`endif

endmodule

// File: tb/tb_bimodal_btb_pred.sv
// Self-checking bench for bimodal_btb_pred (default parameters).
// Honours BP_PERF_CNT_EN when the design is built with it.
module tb_bimodal_btb_pred;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_valid;
    logic        lookup_ready;
    logic [31:0] lookup_pc;
    logic        resp_valid;
    logic        resp_taken;
    logic        resp_btb_hit;
    logic [31:0] resp_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_actual;
    logic [31:0] update_target;
    logic        update_mispredict;
    logic        init_busy;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_lookups;
    logic [31:0] perf_updates;
    logic [31:0] perf_mispredicts;
`endif

    always #5 clk = ~clk;

    bimodal_btb_pred dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .lookup_valid      (lookup_valid),
        .lookup_ready      (lookup_ready),
        .lookup_pc         (lookup_pc),
        .resp_valid        (resp_valid),
        .resp_taken        (resp_taken),
        .resp_btb_hit      (resp_btb_hit),
        .resp_target       (resp_target),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_actual     (update_actual),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
`ifdef BP_PERF_CNT_EN
        .perf_lookups      (perf_lookups),
        .perf_updates      (perf_updates),
        .perf_mispredicts  (perf_mispredicts),
`endif
        .init_busy         (init_busy)
    );

    int nChecks = 0;
    int nFails  = 0;
    bit checkEn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: tables as plain arrays indexed by PC arithmetic.
    int          mPht [256];
    bit          mBv  [32];
    logic [31:0] mTag [32];
    logic [31:0] mTgt [32];
    int          mCycles;
    bit          mRun;
    logic        eValid, eTaken, eHit;
    logic [31:0] eTarget;
    int unsigned mLookups, mUpdates, mMisp;
    int          pi, bi;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mCycles = 0;
            mRun    = 1'b0;
            eValid  = 1'b0;
            eTaken  = 1'b0;
            eHit    = 1'b0;
            eTarget = 32'h0;
            mLookups = 0;
            mUpdates = 0;
            mMisp    = 0;
            for (int i = 0; i < 256; i++) mPht[i] = 1;
            for (int i = 0; i < 32; i++) mBv[i] = 1'b0;
        end else begin
            eValid  = 1'b0;
            eTaken  = 1'b0;
            eHit    = 1'b0;
            eTarget = 32'h0;
            if (mRun && lookup_valid) begin
                pi = int'((lookup_pc >> 2) % 256);
                bi = int'((lookup_pc >> 2) % 32);
                eValid  = 1'b1;
                eHit    = mBv[bi] && (mTag[bi] == (lookup_pc >> 7));
                eTaken  = eHit && (mPht[pi] >= 2);
                eTarget = eTaken ? mTgt[bi] : 32'h0;
                mLookups++;
            end
            if (mRun && update_valid) begin
                pi = int'((update_pc >> 2) % 256);
                bi = int'((update_pc >> 2) % 32);
                if (update_actual) begin
                    if (mPht[pi] < 3) mPht[pi] = mPht[pi] + 1;
                    mBv[bi]  = 1'b1;
                    mTag[bi] = update_pc >> 7;
                    mTgt[bi] = update_target;
                end else begin
                    if (mPht[pi] > 0) mPht[pi] = mPht[pi] - 1;
                end
                mUpdates++;
                if (update_mispredict) mMisp++;
            end
            if (!mRun) begin
                mCycles++;
                if (mCycles == 256) mRun = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn && rst_n) begin
            checkBit("lookup_ready", lookup_ready, mRun);
            checkBit("init_busy", init_busy, !mRun);
            checkBit("resp_valid", resp_valid, eValid);
            checkBit("resp_taken", resp_taken, eTaken);
            checkBit("resp_btb_hit", resp_btb_hit, eHit);
            checkOutput("resp_target", resp_target, eTarget);
`ifdef BP_PERF_CNT_EN
            checkOutput("perf_lookups", perf_lookups, mLookups);
            checkOutput("perf_updates", perf_updates, mUpdates);
            checkOutput("perf_mispredicts", perf_mispredicts, mMisp);
`endif
        end
    end

    // Drive one cycle of inputs at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic lv, input logic [31:0] lpc, input logic uv,
                                 input logic [31:0] upc, input logic ua,
                                 input logic [31:0] ut, input logic um);
        lookup_valid      = lv;
        lookup_pc         = lpc;
        update_valid      = uv;
        update_pc         = upc;
        update_actual     = ua;
        update_target     = ut;
        update_mispredict = um;
        @(negedge clk);
    endtask

    task automatic doLookup(input logic [31:0] pc);
        applyStimulus(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic doUpdate(input logic [31:0] pc, input logic a, input logic [31:0] t);
        applyStimulus(1'b0, 32'h0, 1'b1, pc, a, t, !a);
    endtask

    task automatic waitInit();
        int cnt;
        cnt = 0;
        while (!lookup_ready && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("init_cycles", 32'(cnt), 32'd256);
    endtask

    logic [31:0] lpc, upc;

    initial begin
        rst_n = 1'b1;
        lookup_valid = 1'b0; lookup_pc = '0;
        update_valid = 1'b0; update_pc = '0; update_actual = 1'b0;
        update_target = '0; update_mispredict = 1'b0;
        #3 rst_n = 1'b0;
        #4;
        checkBit("rst_resp_valid", resp_valid, 1'b0);
        checkBit("rst_lookup_ready", lookup_ready, 1'b0);
        checkBit("rst_init_busy", init_busy, 1'b1);
        @(negedge clk);
        rst_n   = 1'b1;
        checkEn = 1'b1;
        waitInit();

        // Cold lookup
        doLookup(32'h100);
        checkBit("cold_valid", resp_valid, 1'b1);
        checkBit("cold_taken", resp_taken, 1'b0);
        checkBit("cold_hit", resp_btb_hit, 1'b0);
        checkOutput("cold_target", resp_target, 32'h0);

        // Two taken updates: counter 1 -> 3, BTB allocated
        doUpdate(32'h100, 1'b1, 32'h200);
        doUpdate(32'h100, 1'b1, 32'h200);
        doLookup(32'h100);
        checkBit("trained_taken", resp_taken, 1'b1);
        checkBit("trained_hit", resp_btb_hit, 1'b1);
        checkOutput("trained_target", resp_target, 32'h200);

        // Saturate, then one not-taken keeps it taken; two more flip it
        for (int i = 0; i < 5; i++) doUpdate(32'h100, 1'b1, 32'h200);
        doUpdate(32'h100, 1'b0, 32'h0);
        doLookup(32'h100);
        checkBit("hyst_taken", resp_taken, 1'b1);
        doUpdate(32'h100, 1'b0, 32'h0);
        doUpdate(32'h100, 1'b0, 32'h0);
        doLookup(32'h100);
        checkBit("nt_taken", resp_taken, 1'b0);
        checkBit("nt_hit", resp_btb_hit, 1'b1);
        checkOutput("nt_target", resp_target, 32'h0);

        // BTB alias: 0x180 evicts 0x100 from the shared entry
        doUpdate(32'h100, 1'b1, 32'h200);
        doUpdate(32'h180, 1'b1, 32'h300);
        doUpdate(32'h180, 1'b1, 32'h300);
        doLookup(32'h100);
        checkBit("alias_hit_100", resp_btb_hit, 1'b0);
        checkBit("alias_taken_100", resp_taken, 1'b0);
        doLookup(32'h180);
        checkOutput("alias_target_180", resp_target, 32'h300);

        // Same-edge lookup and update: lookup sees the old entry
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        checkBit("nobypass_hit", resp_btb_hit, 1'b0);
        doLookup(32'h100);
        checkOutput("after_update_target", resp_target, 32'h200);

        // Low PC bits are ignored
        doUpdate(32'h182, 1'b1, 32'h300);
        doLookup(32'h181);
        checkOutput("lowbits_target", resp_target, 32'h300);

        // Mixed back-to-back traffic with aliasing, checked by the model
        for (int k = 0; k < 40; k++) begin
            lpc = 32'h1000 + 32'((k % 6) * 4) + ((k % 4 == 0) ? 32'h80 : 32'h0);
            upc = 32'h1000 + 32'(((k * 5) % 6) * 4) + ((k % 3 == 0) ? 32'h80 : 32'h0) + 32'(k % 4);
            applyStimulus(1'b1, lpc, 1'b1, upc, (k % 3) != 1, 32'h4000 + 32'(k * 16), (k % 5) == 0);
        end
        for (int k = 0; k < 6; k++) begin
            doLookup(32'h1000 + 32'(k * 4));
            doLookup(32'h1080 + 32'(k * 4));
        end

        // Reset with a response in flight
        lookup_valid = 1'b1;
        lookup_pc    = 32'h180;
        update_valid = 1'b0;
        @(posedge clk);
        #2;
        checkBit("inflight_valid", resp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        checkBit("midrst_valid", resp_valid, 1'b0);
        checkBit("midrst_ready", lookup_ready, 1'b0);
        checkBit("midrst_busy", init_busy, 1'b1);
`ifdef BP_PERF_CNT_EN
        checkOutput("midrst_perf_lookups", perf_lookups, 32'h0);
        checkOutput("midrst_perf_updates", perf_updates, 32'h0);
        checkOutput("midrst_perf_misp", perf_mispredicts, 32'h0);
`endif
        lookup_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        waitInit();
        doLookup(32'h100);
        checkBit("postrst_valid", resp_valid, 1'b1);
        checkBit("postrst_taken", resp_taken, 1'b0);
        checkBit("postrst_hit", resp_btb_hit, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
